lod_norm_frontend: RTL and testbench
====================================

// Module: lod_norm_frontend
// PURPOSE
//  Operand front end of the approximate-multiplier datapath: accepts operand pairs over valid/ready,
//  detects the leading-one position of each, and presents operand plus shift amount (W-1-pos)
//  to the downstream barrel_shifter normalisation stage. Registered, 1-cycle latency,
//  2-entry output buffer so upstream sees full throughput under single-cycle backpressure.
// PARAMETERS
//  W     8   operand width, power of two, >=4
//  SW    3   shift/position width, = log2(W)
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    operand pair present
//  in_ready   out  1    block can accept this cycle
//  in_a       in   W    operand A (unsigned)
//  in_b       in   W    operand B (unsigned)
//  out_valid  out  1    result entry present
//  out_ready  in   1    downstream consumes this cycle
//  out_a      out  W    operand A, unchanged
//  out_b      out  W    operand B, unchanged
//  out_pos_a  out  SW   leading-one index of A (0 = LSB)
//  out_pos_b  out  SW   leading-one index of B
//  out_sh_a   out  SW   shift for A = W-1-pos_a; feeds barrel_shifter shift
//  out_sh_b   out  SW   shift for B = W-1-pos_b
//  out_zero_a out  1    A == 0
//  out_zero_b out  1    B == 0
// BEHAVIOUR
//  - Reset (async assert, sync-release by caller): buffer count=0, out_valid=0, all data/pos/sh/zero
//    outputs 0, in_ready=1 on first cycle after release.
//  - Accept when in_valid&in_ready on rising edge; pop when out_valid&out_ready.
//  - in_ready = (count<2), combinational from registered count only; never depends on in_valid.
//  - Latency: pair accepted at edge N with empty buffer -> out_valid=1 and results visible after edge N.
//  - Buffer: 2-entry FIFO, head drives outputs; strict in-order delivery; outputs stable while
//    out_valid&!out_ready.
//  - count transitions: 0->1 push; 1->1 push+pop; 1->2 push only; 1->0 pop only; 2->1 pop
//    (push impossible at 2). Simultaneous push+pop at count=1: new entry becomes head next cycle.
//  - Position: highest set bit index. Operand 0 -> zero=1, pos=0, sh=0 (data passed through).
//  - sh = (W-1) - pos, unsigned SW bits, no wrap possible (range 0..W-1).
//  - LOD computed combinationally on in_a/in_b, stored with the entry; no computation on pop path.
//  - Reset mid-operation: all buffered entries discarded, no partial output emitted.
//  - in_valid dropped without handshake: nothing stored; in_* ignored when in_valid=0.
// STRUCTURE
//  - Shared header mbm_defs.vh: W/SW defaults, LOD_ZERO_POS constant (0), entry field offsets.
//  - Sub-module leading_one_detector (combinational, W in -> SW pos + zero flag), instantiated
//    twice (A,B). FIFO storage, pointers and count inline in lod_norm_frontend.
// TESTING
//  1. a=8'b0001_0110, b=8'h80, out_ready=1 -> next cycle pos_a=4 sh_a=3, pos_b=7 sh_b=0, zero=0/0.
//  2. a=8'h00, b=8'h01 -> zero_a=1 pos_a=0 sh_a=0; zero_b=0 pos_b=0 sh_b=7; out_a=0, out_b=1.
//  3. out_ready=0, send 3 pairs (11,22,33) back-to-back -> 2 accepted, in_ready=0 on 3rd;
//     raise out_ready -> outputs 11,22,33 in order, outputs stable while stalled.
//  4. out_ready=1, in_valid=1 continuously for 16 pairs -> in_ready stays 1, 16 outputs, 1-cycle lag.
//  5. count=1, push+pop same edge -> count stays 1, head = newly pushed pair next cycle.
//  6. Two entries buffered, assert rst_n=0 mid-cycle -> out_valid=0 and outputs 0 immediately;
//     after release in_ready=1, no stale entry appears.

Source files
------------

// File: rtl/lod_norm_frontend_pkg.sv
// Shared constants for the operand front end of the approximate-multiplier datapath.
package lod_norm_frontend_pkg;

    // Default operand width and matching position/shift width (SW = log2(W)).
    localparam int W_DEF = 8;
    localparam int SW_DEF = 3;

    // Position reported for an all-zero operand.
    localparam int LOD_ZERO_POS = 0;

    // Output buffer depth and width of its occupancy counter.
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W = 2;

endpackage

// File: rtl/lod_norm_frontend_if.sv
// Operand-in / normalised-operand-out handshake bundle.
interface lod_norm_frontend_if
    import lod_norm_frontend_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int SW = SW_DEF
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic [SW-1:0] out_pos_a;
    logic [SW-1:0] out_pos_b;
    logic [SW-1:0] out_sh_a;
    logic [SW-1:0] out_sh_b;
    logic          out_zero_a;
    logic          out_zero_b;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_a, out_b,
        input  out_pos_a, out_pos_b, out_sh_a, out_sh_b, out_zero_a, out_zero_b
    );

    // The front end itself.
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_a, out_b,
        output out_pos_a, out_pos_b, out_sh_a, out_sh_b, out_zero_a, out_zero_b
    );
endinterface

// File: rtl/lod_norm_frontend_lod.sv
// Combinational leading-one detector: index of the highest set bit plus a zero flag.
module leading_one_detector
    import lod_norm_frontend_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int SW = SW_DEF
)
(
    input  logic [W-1:0]  data,
    output logic [SW-1:0] pos,
    output logic          zero
);

    // Scan upward so the last hit, i.e. the highest set bit, wins.
    always_comb begin
        pos = SW'(LOD_ZERO_POS);
        for (int i = 0; i < W; i++) begin
            if (data[i]) begin
                pos = SW'(i);
            end
        end
    end

    assign zero = (data == '0);

endmodule

// File: rtl/lod_norm_frontend.sv
// Operand front end: leading-one detection on both operands, results held in a
// 2-entry FIFO so a single cycle of downstream backpressure costs no throughput.
module lod_norm_frontend
    import lod_norm_frontend_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int SW = SW_DEF
)
(
    input logic               clk,
    input logic               rst_n,
    lod_norm_frontend_if.slave bus
);

    // Entry layout, MSB first: a, b, pos_a, pos_b, sh_a, sh_b, zero_a, zero_b.
    localparam int EW = 2*W + 4*SW + 2;

    logic [CNT_W-1:0] count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [EW-1:0]    head;
    logic [EW-1:0]    entry_in;

    logic             push;
    logic             pop;
    logic [SW-1:0]    pos_a;
    logic [SW-1:0]    pos_b;
    logic [SW-1:0]    sh_a;
    logic [SW-1:0]    sh_b;
    logic             zero_a;
    logic             zero_b;

    leading_one_detector #(.W(W), .SW(SW)) u_lod_a (
        .data (bus.in_a),
        .pos  (pos_a),
        .zero (zero_a)
    );

    leading_one_detector #(.W(W), .SW(SW)) u_lod_b (
        .data (bus.in_b),
        .pos  (pos_b),
        .zero (zero_b)
    );

    // A zero operand needs no normalisation, so its shift is forced to 0 rather than W-1.
    assign sh_a = zero_a ? '0 : SW'(W-1) - pos_a;
    assign sh_b = zero_b ? '0 : SW'(W-1) - pos_b;

    // Ready depends only on registered occupancy, never on in_valid.
    assign bus.in_ready  = (count < CNT_W'(FIFO_DEPTH));
    assign bus.out_valid = (count != '0);

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    assign entry_in = {bus.in_a, bus.in_b, pos_a, pos_b, sh_a, sh_b, zero_a, zero_b};

    // Head entry drives the outputs directly; nothing is computed on the pop path.
    assign head = mem[rd_ptr];
    assign {bus.out_a, bus.out_b, bus.out_pos_a, bus.out_pos_b,
            bus.out_sh_a, bus.out_sh_b, bus.out_zero_a, bus.out_zero_b} = head;

    // Occupancy and read/write pointers; reset discards any buffered entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so every output reads 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= entry_in;
        end
    end

endmodule

// File: tb/tb_lod_norm_frontend.sv
// Directed bench for lod_norm_frontend with immediate-assertion checks.
module tb_lod_norm_frontend;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    lod_norm_frontend_if #(.W(8), .SW(3)) bus ();

    lod_norm_frontend #(.W(8), .SW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference leading-one index: count right shifts until one bit remains.
    function automatic int ref_pos(input logic [7:0] v);
        logic [7:0] t;
        int p;
        t = v;
        p = 0;
        while (t > 8'd1) begin
            t = t >> 1;
            p++;
        end
        return p;
    endfunction

    function automatic int ref_sh(input logic [7:0] v);
        return (v == 8'd0) ? 0 : 7 - ref_pos(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the whole head entry against the reference for operands a/b.
    task automatic check_entry(input string tag, input logic [7:0] a, input logic [7:0] b);
        check({tag, " out_valid"},  32'(bus.out_valid),  32'd1);
        check({tag, " out_a"},      32'(bus.out_a),      32'(a));
        check({tag, " out_b"},      32'(bus.out_b),      32'(b));
        check({tag, " out_pos_a"},  32'(bus.out_pos_a),  32'(ref_pos(a)));
        check({tag, " out_pos_b"},  32'(bus.out_pos_b),  32'(ref_pos(b)));
        check({tag, " out_sh_a"},   32'(bus.out_sh_a),   32'(ref_sh(a)));
        check({tag, " out_sh_b"},   32'(bus.out_sh_b),   32'(ref_sh(b)));
        check({tag, " out_zero_a"}, 32'(bus.out_zero_a), 32'(a == 8'd0));
        check({tag, " out_zero_b"}, 32'(bus.out_zero_b), 32'(b == 8'd0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(1'b0, 8'd0, 8'd0);
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_a",     32'(bus.out_a),     32'd0);
        check("rst out_sh_b",  32'(bus.out_sh_b),  32'd0);
        rst_n = 1'b1;
        tick();
        check("post-rst in_ready",  32'(bus.in_ready),  32'd1);
        check("post-rst out_valid", 32'(bus.out_valid), 32'd0);

        // 1: a=0x16, b=0x80
        bus.out_ready = 1'b1;
        drive(1'b1, 8'h16, 8'h80);
        tick();
        drive(1'b0, 8'hff, 8'hff);
        check("t1 pos_a", 32'(bus.out_pos_a), 32'd4);
        check("t1 sh_a",  32'(bus.out_sh_a),  32'd3);
        check("t1 pos_b", 32'(bus.out_pos_b), 32'd7);
        check("t1 sh_b",  32'(bus.out_sh_b),  32'd0);
        check_entry("t1", 8'h16, 8'h80);
        tick();
        check("t1 drained", 32'(bus.out_valid), 32'd0);

        // 2: zero operand on A, LSB-only on B
        drive(1'b1, 8'h00, 8'h01);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        check("t2 zero_a", 32'(bus.out_zero_a), 32'd1);
        check("t2 pos_a",  32'(bus.out_pos_a),  32'd0);
        check("t2 sh_a",   32'(bus.out_sh_a),   32'd0);
        check("t2 zero_b", 32'(bus.out_zero_b), 32'd0);
        check("t2 pos_b",  32'(bus.out_pos_b),  32'd0);
        check("t2 sh_b",   32'(bus.out_sh_b),   32'd7);
        check("t2 out_b",  32'(bus.out_b),      32'd1);
        tick();
        check("t2 drained", 32'(bus.out_valid), 32'd0);

        // 3: backpressure, three pairs offered, two accepted
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'hee);
        check("t3 ready0", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, 8'h22, 8'hdd);
        check("t3 ready1", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, 8'h33, 8'hcc);
        check("t3 ready full", 32'(bus.in_ready), 32'd0);
        tick();
        check("t3 still full", 32'(bus.in_ready), 32'd0);
        check_entry("t3 stall0", 8'h11, 8'hee);
        tick();
        check_entry("t3 stall1", 8'h11, 8'hee);
        bus.out_ready = 1'b1;
        tick();
        check_entry("t3 second", 8'h22, 8'hdd);
        check("t3 ready reopen", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        check_entry("t3 third", 8'h33, 8'hcc);
        tick();
        check("t3 drained", 32'(bus.out_valid), 32'd0);

        // 4: 16 pairs streamed with out_ready held high
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i * 17), ~8'(i * 17));
            check("t4 in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            check_entry("t4 stream", 8'(i * 17), ~8'(i * 17));
        end
        drive(1'b0, 8'h00, 8'h00);
        tick();
        check("t4 drained", 32'(bus.out_valid), 32'd0);

        // 5: push+pop at count=1
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h40, 8'h05);
        tick();
        check_entry("t5 first", 8'h40, 8'h05);
        bus.out_ready = 1'b1;
        drive(1'b1, 8'h03, 8'h90);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        check_entry("t5 replaced", 8'h03, 8'h90);
        check("t5 count1 ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("t5 drained", 32'(bus.out_valid), 32'd0);

        // 6: reset with two entries buffered
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h7f, 8'h08);
        tick();
        drive(1'b1, 8'h2a, 8'h0c);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        check("t6 full", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 rst out_valid", 32'(bus.out_valid), 32'd0);
        check("t6 rst out_a",     32'(bus.out_a),     32'd0);
        check("t6 rst out_pos_a", 32'(bus.out_pos_a), 32'd0);
        check("t6 rst in_ready",  32'(bus.in_ready),  32'd1);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("t6 no stale",       32'(bus.out_valid), 32'd0);
        check("t6 in_ready after", 32'(bus.in_ready),  32'd1);
        drive(1'b1, 8'h09, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        check_entry("t6 fresh", 8'h09, 8'h00);
        tick();
        check("t6 drained", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
